// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared types and four-state classification for the tri-state bus.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_BUS_WIDTH     = 8;
    localparam int c_BUS_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        BUS_VALID      = 2'd0,
        BUS_FLOAT      = 2'd1,
        BUS_CONTENTION = 2'd2
    } bus_class_t;

    // Synthesis sees no x/z, so hardware always returns BUS_VALID.
    // Callers zero-extend narrower buses; zero bits never change the class.
    function automatic bus_class_t classify_bus(input logic [c_BUS_MAX_WIDTH-1:0] b);
        logic has_x;
        logic has_z;
        has_x = 1'b0;
        has_z = 1'b0;
        for (int i = 0; i < c_BUS_MAX_WIDTH; i++) begin
            if (b[i] === 1'bx) has_x = 1'b1;
            if (b[i] === 1'bz) has_z = 1'b1;
        end
        if (has_x)      return BUS_CONTENTION;
        else if (has_z) return BUS_FLOAT;
        else            return BUS_VALID;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_fifo
// Brief    : Power-of-two circular FIFO; push into full is accepted only with a
//            simultaneous pop. Head word reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module bus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : bus_reader
// Brief    : Samples the shared tri-state bus on request, classifies each
//            sample and queues valid words; errors kept as sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module bus_reader
    import bus_pkg::*;
#(
    parameter int WIDTH = c_BUS_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       bus,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid,
    input  logic                   ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   float_err,
    output logic                   contention_err,
    input  logic                   clr_err
);

    logic [c_BUS_MAX_WIDTH-1:0] w_bus_ext;
    bus_class_t                 w_class;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_drop;
    logic                       w_set_float;
    logic                       w_set_cont;
    logic                       r_overflow;
    logic                       r_float_err;
    logic                       r_cont_err;

    // WIDTH must not exceed c_BUS_MAX_WIDTH.
    always_comb begin
        w_bus_ext              = '0;
        w_bus_ext[WIDTH-1:0]   = bus;
        w_class                = classify_bus(w_bus_ext);
    end

    assign w_pop       = valid && ready;
    assign w_push      = rd_en && (w_class == BUS_VALID);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_set_float = rd_en && (w_class == BUS_FLOAT);
    assign w_set_cont  = rd_en && (w_class == BUS_CONTENTION);

    bus_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus),
        .o_data  (data_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign valid = !w_empty;

    // A new error in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_float_err <= 1'b0;
            r_cont_err  <= 1'b0;
        end else begin
            r_overflow  <= w_drop      || (r_overflow  && !clr_err);
            r_float_err <= w_set_float || (r_float_err && !clr_err);
            r_cont_err  <= w_set_cont  || (r_cont_err  && !clr_err);
        end
    end

    assign overflow       = r_overflow;
    assign float_err      = r_float_err;
    assign contention_err = r_cont_err;

endmodule
`default_nettype wire
